filter_comb_decimator: RTL

- Consumer side of filter_accumulator. Takes the running 20-bit integrator sum and decimates it by DECIM.
- Applies a comb (differentiator) y[k] = x[k] - x[k-DIFF_DELAY] on decimated samples, using modular IN_W arithmetic.
- Emits a scaled OUT_W result through a valid/ready handshake.
- Together with filter_accumulator, forms a single-stage CIC decimator.

---
 rtl/filter_pkg.sv | 19 +
 rtl/filter_decim_counter.sv | 48 ++++
 rtl/filter_comb_decimator.sv | 134 +++++++++++++
 3 files changed

// File: rtl/filter_pkg.sv
// Shared definitions for the CIC filter blocks.
//   FILT_IN_W / FILT_OUT_W : default accumulator and output sample widths
//   comb_state_t           : comb stage state (PRIME fills history, RUN emits)
//   filt_shift()           : number of LSBs dropped when scaling IN_W -> OUT_W
package filter_pkg;

  localparam int FILT_IN_W  = 20;
  localparam int FILT_OUT_W = 16;

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } comb_state_t;

  function automatic int filt_shift(input int in_w, input int out_w);
    return in_w - out_w;
  endfunction

endpackage

// File: rtl/filter_decim_counter.sv
// Decimation counter: counts accepted samples 0..DECIM-1 and flags the tap.
//   clk, rst   : clock, asynchronous active-high reset
//   enable_i   : low freezes the count
//   clear_i    : synchronous restart to 0 (wins over advance)
//   advance_i  : a sample is offered this cycle
//   tap_o      : combinational; this accepted sample is the last of the block
module filter_decim_counter #(
  parameter int DECIM = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic enable_i,
  input  logic clear_i,
  input  logic advance_i,
  output logic tap_o
);

  localparam int              CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DECIM - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step;

  assign step  = enable_i && advance_i && !clear_i;
  assign tap_o = step && (cnt_q == LAST);

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned -- that is what keeps a latch from being inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (step) begin
      cnt_d = tap_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state is written with non-blocking assignments so all
  // registers update together from the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/filter_comb_decimator.sv
// Comb/decimation half of a single-stage CIC decimator. Takes the running
// integrator sum, keeps every DECIM-th accepted sample, computes
// y = x[k] - x[k-DIFF_DELAY] modulo 2^IN_W and emits the upper OUT_W bits
// through a valid/ready handshake.
//   clk, rst   : clock, asynchronous active-high reset
//   enable     : low ignores in_valid (counter, history, state frozen)
//   load       : synchronous restart (history, counter, overrun, out_valid -> 0)
//   in_valid,D : accumulator sample
//   out_ready  : downstream accepts Q
//   out_valid,Q: pending comb result
//   overrun    : sticky, an unconsumed result was overwritten
// Build option: define FILTER_COMB_ROUND_EN to round half-up before scaling;
// otherwise the dropped LSBs are truncated.
module filter_comb_decimator
  import filter_pkg::*;
#(
  parameter int IN_W       = FILT_IN_W,
  parameter int OUT_W      = FILT_OUT_W,
  parameter int DECIM      = 8,
  parameter int DIFF_DELAY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             load,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  D,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] Q,
  output logic             overrun
);

  localparam int SHIFT = filt_shift(IN_W, OUT_W);

  logic tap;

  filter_decim_counter #(
    .DECIM(DECIM)
  ) u_decim_counter (
    .clk       (clk),
    .rst       (rst),
    .enable_i  (enable),
    .clear_i   (load),
    .advance_i (in_valid),
    .tap_o     (tap)
  );

  comb_state_t     state_q, state_d;
  logic [1:0]      prime_cnt_q, prime_cnt_d;
  logic [IN_W-1:0] hist_q [DIFF_DELAY];
  logic [IN_W-1:0] hist_d [DIFF_DELAY];
  logic [IN_W-1:0] diff, scaled;
  logic [OUT_W-1:0] q_q, q_d;
  logic            out_valid_q, out_valid_d;
  logic            overrun_q, overrun_d;
  logic            new_result;

  // Modular subtraction: wrap of the integrator cancels out here.
  always_comb begin
    diff = D - hist_q[DIFF_DELAY-1];
`ifdef FILTER_COMB_ROUND_EN
    scaled = diff + (IN_W'(1) << (SHIFT - 1));
`else
    scaled = diff;
`endif
  end

  assign new_result = tap && (state_q == RUN);

  always_comb begin
    state_d     = state_q;
    prime_cnt_d = prime_cnt_q;
    hist_d      = hist_q;
    q_d         = q_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;

    if (load) begin
      // Q deliberately keeps its last value across a restart.
      state_d     = PRIME;
      prime_cnt_d = '0;
      for (int i = 0; i < DIFF_DELAY; i++) hist_d[i] = '0;
      out_valid_d = 1'b0;
      overrun_d   = 1'b0;
    end else begin
      if (tap) begin
        hist_d[0] = D;
        for (int i = 1; i < DIFF_DELAY; i++) hist_d[i] = hist_q[i-1];
        if (state_q == PRIME) begin
          if (prime_cnt_q == 2'(DIFF_DELAY - 1)) begin
            state_d     = RUN;
            prime_cnt_d = '0;
          end else begin
            prime_cnt_d = prime_cnt_q + 2'd1;
          end
        end
      end

      // A new result wins over a same-edge consume; it only counts as an
      // overrun when the pending value was not being taken.
      if (new_result) begin
        q_d         = scaled[IN_W-1:SHIFT];
        out_valid_d = 1'b1;
        if (out_valid_q && !out_ready) overrun_d = 1'b1;
      end else if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= PRIME;
      prime_cnt_q <= '0;
      for (int i = 0; i < DIFF_DELAY; i++) hist_q[i] <= '0;
      q_q         <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prime_cnt_q <= prime_cnt_d;
      hist_q      <= hist_d;
      q_q         <= q_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_valid = out_valid_q;
  assign Q         = q_q;
  assign overrun   = overrun_q;

endmodule
